ccff_loader: RTL and testbench
==============================

# ccff_loader

Configuration-chain driver for the programmable fabric: accepts a bitstream as words over a valid/ready stream, serializes it MSB-first onto `ccff_head` of the first tile's configuration flip-flop chain, and gates the chain's shifting via `ccff_shift_en`. A verify pass re-shifts the same bitstream and compares every bit that leaves the chain on `ccff_tail` against the bit entering it, flagging configuration corruption. It sits between the bitstream source (SPI or host bridge) and the `ccff_head`/`ccff_tail` ends of the tile chain.

## Interface
Parameters:
- `CHAIN_LEN`, 64: total configuration bits in the chain (≥1).
- `WORD_W`, 8: input word width (≥1).

Ports:
- `prog_clk` in 1: the single clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a pass; sampled only in IDLE.
- `verify` in 1: sampled together with `start`; 1 = verify pass, 0 = load pass.
- `cfg_data` in WORD_W: bitstream word; bit WORD_W-1 is shifted first.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: loader accepts a word this cycle.
- `ccff_head` out 1: serial bit into the chain.
- `ccff_shift_en` out 1: chain shifts on this rising edge of `prog_clk`.
- `ccff_tail` in 1: serial bit out of the last tile of the chain.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at the end of a pass.
- `mismatch` out 1: sticky verify error flag.
- `err_cnt` out 16: saturating count of verify bit mismatches.

## Operation
- States: IDLE, WAIT_WORD, SHIFT, DONE.
- IDLE: `start`=1 → latch `verify`, clear bit counter, `mismatch` and `err_cnt`, then go to WAIT_WORD. When `start`=0, stay in IDLE; `cfg_valid` is ignored.
- WAIT_WORD: `cfg_ready`=1. A word is accepted when `cfg_valid && cfg_ready`. The accepted word is loaded into the word shift register, the per-word bit count is set to min(WORD_W, CHAIN_LEN − bits_sent), and the FSM goes to SHIFT.
- SHIFT: `ccff_shift_en`=1 and `ccff_head` = word register MSB. On each edge:
  - the word register shifts left;
  - `bits_sent` increments.
  - Exit when the per-word count is exhausted: go to DONE if `bits_sent` reaches CHAIN_LEN, otherwise go to WAIT_WORD.
- Final word: when CHAIN_LEN is not a multiple of WORD_W, only the upper (CHAIN_LEN mod WORD_W) bits of the last word are shifted. Its low bits are discarded.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Words consumed per pass: ceil(CHAIN_LEN/WORD_W).
- Verify comparison, active only during a verify pass:
  - Applies on every edge where `ccff_shift_en`=1.
  - If `ccff_tail != ccff_head`: set `mismatch` and increment `err_cnt`, which saturates at 16'hFFFF.
  - Basis: at shift k, the tail holds bit k of the previous pass.
- Load pass: `ccff_tail` is ignored; `mismatch` and `err_cnt` stay at 0.
- `start` when not in IDLE: ignored; no effect on the pass in progress.
- `busy` = (state != IDLE). It is high from the cycle after `start` through the DONE cycle.

## Timing
- Reset values: `cfg_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `mismatch`=0, `err_cnt`=0; state IDLE.
- Reset asserted mid-pass: immediate return to IDLE with the values above. The chain contents are then undefined and the source must restart with a load pass.
- Output sourcing:
  - `ccff_head`, `ccff_shift_en`, `cfg_ready` and `done` are decoded from registered state only; there is no combinational path from inputs.
  - `ccff_shift_en` must be glitch-free, because it drives the chain's shift gating.
- Per-word latency: acceptance edge → first SHIFT cycle on the next cycle. One WAIT_WORD bubble occurs between words, at minimum.
- Minimum pass length, with `cfg_valid` held high: 1 (start) + ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN + 1 (DONE) cycles.
- `cfg_valid` low in WAIT_WORD: the FSM stalls indefinitely and `ccff_shift_en` stays 0, so the chain holds its contents.
- Verify timing: `ccff_tail` is sampled at the same edge that shifts the chain, i.e. the pre-shift tail value is compared.
- Counter update timing: `err_cnt` and `mismatch` update on the shifting edge and are stable by the DONE cycle.

## Test plan
- CHAIN_LEN=20, WORD_W=8, behavioral 20-bit chain model. Load pass with words 8'hA5, 8'h3C, 8'hF0, `cfg_valid` always high → exactly 3 words accepted, 20 `ccff_shift_en` cycles, head sequence 10100101 00111100 1111, `done` pulses once, chain model holds the 20 bits shifted in.
- Same bitstream, verify pass → `mismatch`=0, `err_cnt`=0, tail sequence equals head sequence.
- Verify pass after the bench flips chain bit index 5 → `mismatch`=1, `err_cnt`=1. A subsequent load pass clears both at `start`.
- Throttled source (`cfg_valid` low for 4 cycles before each word) → `ccff_shift_en` low throughout every stall, head sequence unchanged, 20 shifts total.
- `start` pulsed during SHIFT, and `reset` asserted after 10 shifts → the start is ignored; on reset all outputs go to 0 at once, `busy`=0, and a fresh load pass completes normally.
- `err_cnt` saturation (CHAIN_LEN=70000, tail forced to the complement of head, verify) → `err_cnt`=16'hFFFF and it does not wrap.

Source files
------------

// File: rtl/ccff_loader.sv
// Configuration-chain loader: serializes a word stream MSB-first into the fabric's
// ccff chain, and in verify mode compares the chain tail against the re-shifted bitstream.
module ccff_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              mismatch,
  output logic [15:0]       err_cnt
);

  localparam int unsigned BW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned CW = $clog2(WORD_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [BW-1:0]     remaining;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              verify_q, verify_d;
  logic              mismatch_d;
  logic [15:0]       err_d;

  // Next-state, datapath and verify-compare decode
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    bits_d     = bits_q;
    cnt_d      = cnt_q;
    verify_d   = verify_q;
    mismatch_d = mismatch;
    err_d      = err_cnt;
    remaining  = BW'(CHAIN_LEN) - bits_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          verify_d   = verify;
          bits_d     = '0;
          mismatch_d = 1'b0;
          err_d      = 16'h0000;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cfg_valid) begin
          word_d  = cfg_data;
          // Last word of a non-multiple chain only contributes its upper bits
          cnt_d   = (32'(remaining) >= WORD_W) ? CW'(WORD_W) : CW'(remaining);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        word_d = word_q << 1;
        bits_d = bits_q + BW'(1);
        cnt_d  = cnt_q - CW'(1);
        // Pre-shift tail is compared against the bit entering the chain on this edge
        if (verify_q && (ccff_tail != word_q[WORD_W-1])) begin
          mismatch_d = 1'b1;
          if (err_cnt != 16'hFFFF) begin
            err_d = err_cnt + 16'h0001;
          end
        end
        if (cnt_q == CW'(1)) begin
          state_d = (bits_d == BW'(CHAIN_LEN)) ? S_DONE : S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs are flops so shift_en is glitch-free
  always_ff @(posedge prog_clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      word_q        <= '0;
      bits_q        <= '0;
      cnt_q         <= '0;
      verify_q      <= 1'b0;
      mismatch      <= 1'b0;
      err_cnt       <= 16'h0000;
      cfg_ready     <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      bits_q        <= bits_d;
      cnt_q         <= cnt_d;
      verify_q      <= verify_d;
      mismatch      <= mismatch_d;
      err_cnt       <= err_d;
      cfg_ready     <= (state_d == S_WAIT);
      ccff_head     <= (state_d == S_SHIFT) & word_d[WORD_W-1];
      ccff_shift_en <= (state_d == S_SHIFT);
      busy          <= (state_d != S_IDLE);
      done          <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader: 20-bit behavioural chain, table of passes,
// mid-pass reset sequence, and a 70000-bit verify pass for err_cnt saturation.
module tb_ccff_loader;

  localparam int unsigned CL     = 20;
  localparam int unsigned WW     = 8;
  localparam int unsigned BIG_CL = 70000;
  localparam int unsigned BIG_WW = 32;
  localparam logic [CL-1:0] BITS = 20'hA53CF;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic          reset = 1'b1;
  logic          start = 1'b0, verify = 1'b0, cfg_valid = 1'b0;
  logic [WW-1:0] cfg_data = '0;
  logic          cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done, mismatch;
  logic [15:0]   err_cnt;

  logic              start_b = 1'b0, verify_b = 1'b0, valid_b = 1'b1;
  logic [BIG_WW-1:0] data_b = 32'hDEADBEEF;
  logic              ready_b, head_b, shen_b, tail_b, busy_b, done_b, mm_b;
  logic [15:0]       err_b;

  ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
    .prog_clk(prog_clk), .reset(reset), .start(start), .verify(verify),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .mismatch(mismatch), .err_cnt(err_cnt));

  ccff_loader #(.CHAIN_LEN(BIG_CL), .WORD_W(BIG_WW)) u_big (
    .prog_clk(prog_clk), .reset(reset), .start(start_b), .verify(verify_b),
    .cfg_data(data_b), .cfg_valid(valid_b), .cfg_ready(ready_b),
    .ccff_head(head_b), .ccff_shift_en(shen_b), .ccff_tail(tail_b),
    .busy(busy_b), .done(done_b), .mismatch(mm_b), .err_cnt(err_b));

  assign tail_b = ~head_b;

  // Behavioural chain; flip_mask lets the bench corrupt a stored bit
  logic [CL-1:0] chain = '0;
  logic [CL-1:0] flip_mask = '0;
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk)
    chain <= (ccff_shift_en ? {chain[CL-2:0], ccff_head} : chain) ^ flip_mask;

  int n_shift = 0, n_words = 0, n_done = 0, n_busy = 0, n_viol = 0;
  logic [CL-1:0] head_hist = '0, tail_hist = '0;
  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      n_shift   <= n_shift + 1;
      head_hist <= {head_hist[CL-2:0], ccff_head};
      tail_hist <= {tail_hist[CL-2:0], ccff_tail};
      if (cfg_ready) n_viol <= n_viol + 1;
    end
    if (cfg_valid && cfg_ready) n_words <= n_words + 1;
    if (done) n_done <= n_done + 1;
    if (busy) n_busy <= n_busy + 1;
  end

  int n_cmp = 0, n_err = 0;
  logic [WW-1:0] words [3] = '{8'hA5, 8'h3C, 8'hF0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          verify;
    logic          flip;
    logic          throttle;
    logic          glitch;
    logic          exp_mm;
    logic [15:0]   exp_err;
    logic [CL-1:0] exp_tail;
    int            exp_busy;
  } vec_t;

  vec_t tbl [6];

  task automatic run_pass(input vec_t t, input int idx);
    int b_shift, b_words, b_done, b_busy, b_viol, tmo;
    logic ok;
    if (t.flip) begin
      @(negedge prog_clk); flip_mask = 20'h00020;
      @(negedge prog_clk); flip_mask = '0;
    end
    @(negedge prog_clk);
    b_shift = n_shift; b_words = n_words; b_done = n_done; b_busy = n_busy; b_viol = n_viol;
    start = 1'b1; verify = t.verify;
    @(negedge prog_clk);
    start = 1'b0; verify = 1'b0;
    check($sformatf("p%0d_clr_at_start", idx), {31'b0, mismatch} | 32'(err_cnt), 32'd0);
    for (int w = 0; w < 3; w++) begin
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (cfg_ready) begin ok = 1'b1; break; end
        @(negedge prog_clk);
      end
      if (!ok) begin
        check($sformatf("p%0d_ready_timeout", idx), 32'd0, 32'd1);
        return;
      end
      if (t.throttle) repeat (4) @(negedge prog_clk);
      cfg_valid = 1'b1; cfg_data = words[w];
      @(negedge prog_clk);
      cfg_valid = 1'b0; cfg_data = '0;
      if (t.glitch && w == 0) begin
        @(negedge prog_clk); @(negedge prog_clk);
        start = 1'b1; verify = 1'b1;
        @(negedge prog_clk);
        start = 1'b0; verify = 1'b0;
      end
    end
    tmo = 0;
    while (!done && tmo < 200) begin @(negedge prog_clk); tmo++; end
    check($sformatf("p%0d_done_seen", idx), {31'b0, done}, 32'd1);
    @(negedge prog_clk);
    check($sformatf("p%0d_done_one_cycle", idx), {30'b0, done, busy}, 32'd0);
    check($sformatf("p%0d_done_pulses", idx), 32'(n_done - b_done), 32'd1);
    check($sformatf("p%0d_words", idx), 32'(n_words - b_words), 32'd3);
    check($sformatf("p%0d_shifts", idx), 32'(n_shift - b_shift), 32'd20);
    check($sformatf("p%0d_busy_cycles", idx), 32'(n_busy - b_busy), 32'(t.exp_busy));
    check($sformatf("p%0d_shift_in_wait", idx), 32'(n_viol - b_viol), 32'd0);
    check($sformatf("p%0d_head_seq", idx), 32'(head_hist), 32'(BITS));
    check($sformatf("p%0d_tail_seq", idx), 32'(tail_hist), 32'(t.exp_tail));
    check($sformatf("p%0d_chain", idx), 32'(chain), 32'(BITS));
    check($sformatf("p%0d_mismatch", idx), {31'b0, mismatch}, {31'b0, t.exp_mm});
    check($sformatf("p%0d_err_cnt", idx), 32'(err_cnt), 32'(t.exp_err));
  endtask

  initial begin
    vec_t post;
    int b_shift, b_words, tmo;
    //          verify flip  thr   glitch mm    err    tail              busy
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 20'h00000,        24};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, BITS,             24};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, BITS ^ 20'h00020, 24};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, BITS,             36};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, BITS,             36};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, BITS ^ 20'h00020, 24};

    #1;
    check("reset_outputs", {25'b0, cfg_ready, ccff_head, ccff_shift_en, busy, done, mismatch, |err_cnt}, 32'd0);
    repeat (3) @(negedge prog_clk);
    reset = 1'b0;

    // cfg_valid in IDLE without start must be ignored
    b_words = n_words; b_shift = n_shift;
    cfg_valid = 1'b1; cfg_data = 8'hFF;
    repeat (3) @(negedge prog_clk);
    check("idle_ready_low", {30'b0, cfg_ready, busy}, 32'd0);
    check("idle_no_activity", 32'(n_words - b_words + n_shift - b_shift), 32'd0);
    cfg_valid = 1'b0; cfg_data = '0;

    for (int i = 0; i < 6; i++) run_pass(tbl[i], i);

    // Reset after 10 shifts of a load pass
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    b_shift = n_shift;
    for (int w = 0; w < 2; w++) begin
      tmo = 0;
      while (!cfg_ready && tmo < 100) begin @(negedge prog_clk); tmo++; end
      cfg_valid = 1'b1; cfg_data = words[w];
      @(negedge prog_clk);
      cfg_valid = 1'b0;
    end
    tmo = 0;
    while ((n_shift - b_shift) < 10 && tmo < 100) begin @(negedge prog_clk); tmo++; end
    check("rst_shifts_before", 32'(n_shift - b_shift), 32'd10);
    check("rst_shift_en_before", {31'b0, ccff_shift_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_outputs", {25'b0, cfg_ready, ccff_head, ccff_shift_en, busy, done, mismatch, |err_cnt}, 32'd0);
    @(negedge prog_clk);
    check("rst_no_extra_shift", 32'(n_shift - b_shift), 32'd10);
    reset = 1'b0;
    post = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 20'hF3E94, 24};
    run_pass(post, 6);

    // 70000-bit verify with tail = ~head: err_cnt must stick at FFFF
    @(negedge prog_clk);
    start_b = 1'b1; verify_b = 1'b1;
    @(negedge prog_clk);
    start_b = 1'b0; verify_b = 1'b0;
    tmo = 0;
    while (!done_b && tmo < 80000) begin @(negedge prog_clk); tmo++; end
    check("big_done", {31'b0, done_b}, 32'd1);
    check("big_err_sat", 32'(err_b), 32'h0000FFFF);
    check("big_mismatch", {31'b0, mm_b}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
